axis_dual_boxcar_averager: RTL and testbench
============================================

AXIS_DUAL_BOXCAR_AVERAGER -- requirements
Module: axis_dual_boxcar_averager

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: signed sample width per channel.
REQ-002 The block SHALL have parameter MAX_SHIFT, default 8: maximum log2 averaging length; accumulator width ACC_WIDTH = DATA_WIDTH+MAX_SHIFT.
REQ-003 The block SHALL have port aclk, input, 1: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port enable, input, 1: high = averaging active.
REQ-006 The block SHALL have port shift, input, 4: log2 of block length N; values above MAX_SHIFT clamp to MAX_SHIFT.
REQ-007 The block SHALL have port S_AXIS_S0_tdata, input, DATA_WIDTH: channel 0 signed sample.
REQ-008 The block SHALL have port S_AXIS_S0_tvalid, input, 1: channel 0 valid.
REQ-009 The block SHALL have port S_AXIS_S1_tdata, input, DATA_WIDTH: channel 1 signed sample.
REQ-010 The block SHALL have port S_AXIS_S1_tvalid, input, 1: channel 1 valid.
REQ-011 The block SHALL have port M_AXIS_AVG_tdata, output, 2*DATA_WIDTH: {avg1, avg0}, avg0 in low half.
REQ-012 The block SHALL have port M_AXIS_AVG_tvalid, output, 1: result valid.
REQ-013 The block SHALL have port M_AXIS_AVG_tready, input, 1: downstream accept.
REQ-014 The block SHALL have port overrun, output, 1: sticky flag, unaccepted result overwritten.

Function
REQ-015 The inputs SHALL have no tready; upstream is free-running and the block always accepts.
REQ-016 A sample pair SHALL be accepted only in a cycle with enable=1, S_AXIS_S0_tvalid=1 and S_AXIS_S1_tvalid=1; a cycle with only one tvalid high SHALL be ignored for both channels.
REQ-017 The block SHALL have states IDLE and ACCUM; IDLE->ACCUM when enable=1; ACCUM->IDLE when enable=0, discarding the partial block (acc0, acc1, count cleared).
REQ-018 The effective shift s SHALL be latched when the first sample of a block is accepted (count=0); shift changes mid-block SHALL NOT affect that block.
REQ-019 acc0/acc1 SHALL sign-extend and sum the accepted samples at ACC_WIDTH bits; count SHALL increment per accepted pair.
REQ-020 On the accepted pair with count=N-1 (N=2^s), the result SHALL be (acc+sample+R) arithmetic-shifted right by s, where R=2^(s-1) for s>0 and R=0 for s=0, truncated to DATA_WIDTH (no overflow possible); acc and count SHALL restart at 0.
REQ-021 The result SHALL appear on M_AXIS_AVG_tdata with M_AXIS_AVG_tvalid=1 on the clock edge after the final sample edge (1-cycle latency).
REQ-022 tdata/tvalid SHALL hold stable until tvalid&&tready; on that cycle tvalid SHALL drop unless a new result loads simultaneously.
REQ-023 If a new result completes while tvalid=1 and tready=0, the new result SHALL overwrite tdata, tvalid SHALL stay 1, and overrun SHALL set.
REQ-024 If a new result completes in the cycle tvalid=1 and tready=1, the old result SHALL count as delivered, the new one SHALL load, and overrun SHALL NOT set.
REQ-025 overrun SHALL stay set until enable=0, which SHALL clear it; a pending valid result SHALL remain held across enable=0 until accepted.
REQ-026 With s=0 every accepted pair SHALL produce one output equal to the input pair.

Reset
REQ-027 aresetn=0 SHALL immediately set state=IDLE, acc0=acc1=0, count=0, latched s=0, M_AXIS_AVG_tdata=0, M_AXIS_AVG_tvalid=0, overrun=0.
REQ-028 Reset mid-block or with a pending result SHALL discard both; after release the first accepted pair SHALL start a new block.

Verification
REQ-029 shift=2, S0=100,101,102,103, S1=-5,-6,-7,-8, tready=1 -> one tdata=0xFFFA0066 one cycle after the 4th pair, tvalid high for exactly 1 cycle.
REQ-030 shift=0, pair S0=0x1234, S1=0x8000 -> tdata=0x80001234 next cycle; S0_tvalid=1 with S1_tvalid=0 -> no output, count unchanged.
REQ-031 shift=8, 256 pairs S0=32767, S1=-32768 -> tdata=0x80007FFF; shift changed to 1 after pair 10 -> still 256-pair block.
REQ-032 shift=1, tready=0, pairs (1,1),(3,3),(5,5),(7,7) -> tdata=0x00020002 then 0x00060006, tvalid held, overrun=1; enable=0 -> overrun=0, tvalid still 1 until tready.
REQ-033 shift=2, 2 pairs accepted then aresetn pulsed low -> all outputs 0; next 4 pairs of 8 -> tdata=0x00080008.
REQ-034 Pending result, tready=1 in the same cycle a new block completes -> old word transferred, new word valid next, overrun stays 0.

Source files
------------

// File: rtl/axis_dual_boxcar_averager_if.sv
// AXI-Stream style link used by the dual boxcar averager.
// The consumer modport carries no tready: the averager never stalls its
// free-running sample sources, so backpressure only exists on the result side.
interface axis_dual_boxcar_averager_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    // Producer side: drives data/valid and observes backpressure.
    modport master (output tdata, output tvalid, input tready);
    // Consumer side without backpressure.
    modport slave  (input tdata, input tvalid);
endinterface

// File: rtl/axis_dual_boxcar_averager.sv
// Dual-channel boxcar averager: sums 2^s sample pairs per channel and emits
// the rounded mean of both channels as one word, with a one-deep output
// register that overwrites (and flags overrun) when downstream stalls.

// Per-channel accumulator and rounding datapath.
module axis_dual_boxcar_averager_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_SHIFT  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  clear,
    input  logic                  accept,
    input  logic                  last,
    input  logic [3:0]            s_cur,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int ACC_WIDTH = DATA_WIDTH + MAX_SHIFT;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;
    logic        [ACC_WIDTH-1:0] rnd;
    logic signed [ACC_WIDTH-1:0] rounded;
    logic signed [ACC_WIDTH-1:0] shifted;

    // Running sum plus half-LSB rounding and arithmetic divide by 2^s.
    // rnd is 2^(s-1) for s>0 and 0 for s=0; the headroom of MAX_SHIFT bits
    // guarantees neither the sum nor the rounding term can overflow.
    always_comb begin
        sum     = acc + {{MAX_SHIFT{sample[DATA_WIDTH-1]}}, sample};
        rnd     = ({{(ACC_WIDTH-1){1'b0}}, 1'b1} << s_cur) >> 1;
        rounded = sum + rnd;
        shifted = $signed(rounded) >>> s_cur;
        result  = shifted[DATA_WIDTH-1:0];
    end

    // Accumulator: restarts after the final pair of a block or on abort.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (accept) begin
            acc <= last ? '0 : sum;
        end
    end
endmodule

module axis_dual_boxcar_averager #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_SHIFT  = 8
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               enable,
    input  logic [3:0]                         shift,
    axis_dual_boxcar_averager_if.slave         S_AXIS_S0,
    axis_dual_boxcar_averager_if.slave         S_AXIS_S1,
    axis_dual_boxcar_averager_if.master        M_AXIS_AVG,
    output logic                               overrun
);
    localparam int NUM_LANES = 2;
    localparam int CNT_W     = MAX_SHIFT + 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                               state, state_nxt;
    logic                                 accept, clear, last, load;
    logic [3:0]                           s_eff, s_lat, s_cur;
    logic [CNT_W-1:0]                     count, last_cnt;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] samples, results;

    assign samples[0] = S_AXIS_S0.tdata;
    assign samples[1] = S_AXIS_S1.tdata;

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state: enable alone moves between idle and accumulating.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = ACCUM;
            ACCUM:   if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: a pair is taken only when both channels are valid;
    // dropping enable while accumulating throws the partial block away.
    always_comb begin
        accept = enable && S_AXIS_S0.tvalid && S_AXIS_S1.tvalid;
        clear  = (state == ACCUM) && !enable;
    end

    // Block length: the first pair of a block uses the live (clamped) shift,
    // later pairs use the value latched on that first pair.
    always_comb begin
        s_eff    = (shift > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : shift;
        s_cur    = (count == '0) ? s_eff : s_lat;
        last_cnt = (CNT_W'(1) << s_cur) - CNT_W'(1);
        last     = (count == last_cnt);
        load     = accept && last;
    end

    // Pair counter and shift latch.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
            s_lat <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (accept) begin
            if (count == '0) s_lat <= s_eff;
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        axis_dual_boxcar_averager_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_SHIFT  (MAX_SHIFT)
        ) u_lane (
            .aclk    (aclk),
            .aresetn (aresetn),
            .clear   (clear),
            .accept  (accept),
            .last    (last),
            .s_cur   (s_cur),
            .sample  (samples[l]),
            .result  (results[l])
        );
    end

    // Output register: a fresh result always wins over the handshake, so a
    // simultaneous accept-and-load leaves tvalid high with the new word.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            M_AXIS_AVG.tdata  <= '0;
            M_AXIS_AVG.tvalid <= 1'b0;
        end else if (load) begin
            M_AXIS_AVG.tdata  <= results;
            M_AXIS_AVG.tvalid <= 1'b1;
        end else if (M_AXIS_AVG.tvalid && M_AXIS_AVG.tready) begin
            M_AXIS_AVG.tvalid <= 1'b0;
        end
    end

    // Sticky overrun: set when an unaccepted word is replaced, cleared by
    // dropping enable (a pending word is left untouched).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overrun <= 1'b0;
        end else if (!enable) begin
            overrun <= 1'b0;
        end else if (load && M_AXIS_AVG.tvalid && !M_AXIS_AVG.tready) begin
            overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_dual_boxcar_averager.sv
// Bench for the dual boxcar averager: directed scenarios plus a randomized
// run, all compared against a transaction-level reference model.
module tb_axis_dual_boxcar_averager;
    localparam int DW = 16;
    localparam int MS = 8;

    logic       aclk    = 1'b0;
    logic       aresetn = 1'b0;
    logic       enable  = 1'b0;
    logic [3:0] shift   = 4'd0;
    logic       overrun;

    axis_dual_boxcar_averager_if #(.WIDTH(DW))   s0_if ();
    axis_dual_boxcar_averager_if #(.WIDTH(DW))   s1_if ();
    axis_dual_boxcar_averager_if #(.WIDTH(2*DW)) m_if ();

    assign s0_if.tready = 1'b1;
    assign s1_if.tready = 1'b1;

    axis_dual_boxcar_averager #(.DATA_WIDTH(DW), .MAX_SHIFT(MS)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .enable     (enable),
        .shift      (shift),
        .S_AXIS_S0  (s0_if),
        .S_AXIS_S1  (s1_if),
        .M_AXIS_AVG (m_if),
        .overrun    (overrun)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model state: block sums, pair count, block shift, output word.
    longint          m_sum0, m_sum1;
    int              m_cnt, m_s;
    logic            exp_valid, exp_ovr;
    logic [2*DW-1:0] exp_data;

    function automatic longint floor_div(input longint num, input longint den);
        longint q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [DW-1:0] block_avg(input longint sum, input int s);
        longint n, a;
        n = longint'(1) << s;
        a = floor_div(sum + n / 2, n);
        return a[DW-1:0];
    endfunction

    task automatic model_reset();
        m_sum0 = 0; m_sum1 = 0; m_cnt = 0; m_s = 0;
        exp_valid = 1'b0; exp_ovr = 1'b0; exp_data = '0;
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // move 1 time unit past the edge so outputs are sampled away from it.
    task automatic tick();
        logic            done;
        logic [2*DW-1:0] word;
        done = 1'b0;
        word = '0;
        @(posedge aclk);
        if (!aresetn) begin
            model_reset();
        end else begin
            if (enable && s0_if.tvalid && s1_if.tvalid) begin
                if (m_cnt == 0) m_s = (int'(shift) > MS) ? MS : int'(shift);
                m_sum0 += longint'($signed(s0_if.tdata));
                m_sum1 += longint'($signed(s1_if.tdata));
                m_cnt++;
                if (m_cnt == (1 << m_s)) begin
                    word = {block_avg(m_sum1, m_s), block_avg(m_sum0, m_s)};
                    done = 1'b1;
                    m_sum0 = 0; m_sum1 = 0; m_cnt = 0;
                end
            end else if (!enable) begin
                m_sum0 = 0; m_sum1 = 0; m_cnt = 0;
            end
            if (done) begin
                if (exp_valid && !m_if.tready) exp_ovr = 1'b1;
                exp_valid = 1'b1;
                exp_data  = word;
            end else if (exp_valid && m_if.tready) begin
                exp_valid = 1'b0;
            end
            if (!enable) exp_ovr = 1'b0;
        end
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] sh,
                         input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1,
                         input logic rdy);
        enable = en; shift = sh;
        s0_if.tvalid = v0; s0_if.tdata = d0;
        s1_if.tvalid = v1; s1_if.tdata = d1;
        m_if.tready = rdy;
        tick();
    endtask

    // Drop enable with tready high so every test starts clean.
    task automatic quiesce();
        drive(1'b0, 4'd0, 1'b0, '0, 1'b0, '0, 1'b1);
        drive(1'b0, 4'd0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        drive(1'b0, 4'd0, 1'b0, '0, 1'b0, '0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, '0, 1'b0, '0, 1'b0);
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_if.tvalid); end
        checks++; if (m_if.tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", m_if.tdata); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        quiesce();
        drive(1'b1, 4'd2, 1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd2, 1'b1, DW'(100 + i), 1'b1, DW'(-5 - i), 1'b1);
            if (i < 3) begin
                checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL basic_early_tvalid pair=%0d got=%b exp=0", i, m_if.tvalid); end
            end
        end
        checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL basic_tvalid got=%b exp=1", m_if.tvalid); end
        checks++; if (m_if.tdata !== 32'hFFFA0066) begin errors++; $display("FAIL basic_tdata got=%h exp=FFFA0066", m_if.tdata); end
        checks++; if (m_if.tdata !== exp_data) begin errors++; $display("FAIL basic_model got=%h exp=%h", m_if.tdata, exp_data); end
        drive(1'b1, 4'd2, 1'b0, '0, 1'b0, '0, 1'b1);
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got=%b exp=0", m_if.tvalid); end
    endtask

    task automatic test_passthrough();
        quiesce();
        drive(1'b1, 4'd0, 1'b1, 16'h1234, 1'b1, 16'h8000, 1'b1);
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h80001234) begin errors++; $display("FAIL pass_tdata got=%b/%h exp=1/80001234", m_if.tvalid, m_if.tdata); end
        drive(1'b1, 4'd1, 1'b1, 16'd10, 1'b1, 16'd20, 1'b1);
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL pass_drop got=%b exp=0", m_if.tvalid); end
        drive(1'b1, 4'd1, 1'b1, 16'd1000, 1'b0, 16'd1000, 1'b1);
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL pass_half_valid got=%b exp=0", m_if.tvalid); end
        drive(1'b1, 4'd1, 1'b1, 16'd12, 1'b1, 16'd22, 1'b1);
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h0015000B) begin errors++; $display("FAIL pass_ignore_half got=%b/%h exp=1/0015000B", m_if.tvalid, m_if.tdata); end
    endtask

    task automatic test_long_block();
        int early;
        logic [3:0] sh;
        early = 0;
        quiesce();
        sh = 4'd8;
        for (int i = 0; i < 256; i++) begin
            if (i == 10) sh = 4'd1;
            drive(1'b1, sh, 1'b1, 16'h7FFF, 1'b1, 16'h8000, 1'b1);
            if (i < 255 && m_if.tvalid !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL long_early_outputs got=%0d exp=0", early); end
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h80007FFF) begin errors++; $display("FAIL long_tdata got=%b/%h exp=1/80007FFF", m_if.tvalid, m_if.tdata); end
    endtask

    task automatic test_overrun();
        quiesce();
        drive(1'b1, 4'd1, 1'b1, 16'd1, 1'b1, 16'd1, 1'b0);
        drive(1'b1, 4'd1, 1'b1, 16'd3, 1'b1, 16'd3, 1'b0);
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h00020002) begin errors++; $display("FAIL ovr_first got=%b/%h exp=1/00020002", m_if.tvalid, m_if.tdata); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_not_yet got=%b exp=0", overrun); end
        drive(1'b1, 4'd1, 1'b1, 16'd5, 1'b1, 16'd5, 1'b0);
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h00020002) begin errors++; $display("FAIL ovr_hold got=%b/%h exp=1/00020002", m_if.tvalid, m_if.tdata); end
        drive(1'b1, 4'd1, 1'b1, 16'd7, 1'b1, 16'd7, 1'b0);
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h00060006) begin errors++; $display("FAIL ovr_second got=%b/%h exp=1/00060006", m_if.tvalid, m_if.tdata); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        drive(1'b0, 4'd1, 1'b0, '0, 1'b0, '0, 1'b0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h00060006) begin errors++; $display("FAIL ovr_held_disabled got=%b/%h exp=1/00060006", m_if.tvalid, m_if.tdata); end
        drive(1'b0, 4'd1, 1'b0, '0, 1'b0, '0, 1'b1);
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b exp=0", m_if.tvalid); end
    endtask

    task automatic test_reset_mid();
        quiesce();
        drive(1'b1, 4'd0, 1'b1, 16'd3, 1'b1, 16'd4, 1'b0);
        drive(1'b1, 4'd0, 1'b1, 16'd5, 1'b1, 16'd6, 1'b0);
        drive(1'b1, 4'd2, 1'b1, 16'd1, 1'b1, 16'd1, 1'b0);
        drive(1'b1, 4'd2, 1'b1, 16'd1, 1'b1, 16'd1, 1'b0);
        checks++; if (overrun !== 1'b1 || m_if.tvalid !== 1'b1) begin errors++; $display("FAIL rst_setup got=%b/%b exp=1/1", overrun, m_if.tvalid); end
        s0_if.tvalid = 1'b0; s1_if.tvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        model_reset();
        checks++; if (m_if.tvalid !== 1'b0 || m_if.tdata !== 32'h0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_async got=%b/%h/%b exp=0/0/0", m_if.tvalid, m_if.tdata, overrun); end
        tick();
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd2, 1'b1, 16'd8, 1'b1, 16'd8, 1'b1);
            if (i < 3) begin
                checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_early pair=%0d got=%b exp=0", i, m_if.tvalid); end
            end
        end
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h00080008) begin errors++; $display("FAIL rst_new_block got=%b/%h exp=1/00080008", m_if.tvalid, m_if.tdata); end
    endtask

    task automatic test_back_to_back();
        quiesce();
        drive(1'b1, 4'd1, 1'b1, 16'd2, 1'b1, 16'd4, 1'b0);
        drive(1'b1, 4'd1, 1'b1, 16'd4, 1'b1, 16'd8, 1'b0);
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h00060003) begin errors++; $display("FAIL b2b_pending got=%b/%h exp=1/00060003", m_if.tvalid, m_if.tdata); end
        drive(1'b1, 4'd1, 1'b1, 16'd10, 1'b1, 16'd20, 1'b0);
        drive(1'b1, 4'd1, 1'b1, 16'd12, 1'b1, 16'd22, 1'b1);
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h0015000B) begin errors++; $display("FAIL b2b_new got=%b/%h exp=1/0015000B", m_if.tvalid, m_if.tdata); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
        drive(1'b1, 4'd1, 1'b0, '0, 1'b0, '0, 1'b1);
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", m_if.tvalid); end
    endtask

    task automatic test_random();
        logic       en;
        logic [3:0] sh;
        int         bad_v, bad_d, bad_o, words;
        en = 1'b1; sh = 4'd2;
        bad_v = 0; bad_d = 0; bad_o = 0; words = 0;
        quiesce();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0)
                sh = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            drive(en, sh, ($urandom_range(0, 3) != 0), DW'($urandom),
                  ($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom));
            if (exp_valid) words++;
            if (m_if.tvalid !== exp_valid) begin
                bad_v++;
                if (bad_v <= 5) $display("FAIL rand_tvalid cycle=%0d got=%b exp=%b", c, m_if.tvalid, exp_valid);
            end
            if (exp_valid && m_if.tdata !== exp_data) begin
                bad_d++;
                if (bad_d <= 5) $display("FAIL rand_tdata cycle=%0d got=%h exp=%h", c, m_if.tdata, exp_data);
            end
            if (overrun !== exp_ovr) begin
                bad_o++;
                if (bad_o <= 5) $display("FAIL rand_overrun cycle=%0d got=%b exp=%b", c, overrun, exp_ovr);
            end
        end
        checks++; if (bad_v != 0) errors++;
        checks++; if (bad_d != 0) errors++;
        checks++; if (bad_o != 0) errors++;
        checks++; if (words == 0) begin errors++; $display("FAIL rand_no_results got=0 exp>0"); end
    endtask

    initial begin
        s0_if.tvalid = 1'b0; s0_if.tdata = '0;
        s1_if.tvalid = 1'b0; s1_if.tdata = '0;
        m_if.tready  = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_passthrough();
        test_long_block();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
